uart_tx_shift: RTL and testbench
================================

Name: uart_tx_shift

Overview:
- Transmit frame builder and shift engine for the UART TX path. Sits beside the TX bit counter.
- Drives that counter's doit input and shares its btu strobe. Consumes the counter's done to end a frame.
- Takes a byte plus framing configuration (7/8 data bits, parity on/off, odd/even) on a load strobe. Builds an 11-bit frame and shifts it out LSB-first onto the serial tx line, one bit per btu.

Parameters:
- FRAME_W, 11, shift register width (idle pad + start + 7 data + bit9 + bit10).
- IDLE_LVL, 1'b1, line level shifted in behind the frame and driven at reset.

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  synchronous, active-high reset
- btu  in  1  one-clk bit-time-up strobe from baud generator
- done  in  1  from bit counter; high when 11 bit times have elapsed
- load  in  1  one-clk request to transmit out_port
- out_port  in  8  byte to transmit
- eight  in  1  1 = 8 data bits, 0 = 7 data bits
- pen  in  1  parity enable
- ohel  in  1  1 = odd parity, 0 = even parity
- doit  out  1  frame in progress; feeds bit counter
- tx  out  1  serial output
- tx_rdy  out  1  high when a new load will be accepted

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on posedge clk only.
- Reset values: shift reg all IDLE_LVL, tx=1, doit=0, tx_rdy=1, load_d1=0, captured data/config regs=0.
- Accept: load && tx_rdy at edge N.
  - Edge N: register out_port, eight, pen, ohel; set load_d1=1; tx_rdy<=0.
- Edge N+1 (load_d1=1):
  - Shift reg <= {bit10, bit9, data[6:0], 1'b0, 1'b1}.
  - doit<=1; load_d1<=0.
- bit9/bit10 from the registered config (P = ^data[6:0] when eight=0, ^data[7:0] when eight=1; parity bit = P for even, ~P for odd):
  - eight=0, pen=0: 1, 1
  - eight=0, pen=1: bit9=parity, bit10=1
  - eight=1, pen=0: bit9=data[7], bit10=1
  - eight=1, pen=1: bit9=data[7], bit10=parity
- Shift: when doit && btu && !load_d1, shift reg <= {IDLE_LVL, sr[10:1]}. tx = sr[0], registered.
- End: done=1 at edge → doit<=0. tx_rdy<=1 on the following edge (one idle clk guard).
- Load while !tx_rdy: ignored, no state change, no queuing.
- load_d1 and btu in the same cycle: the parallel load wins and the shift is dropped.
- done and load in the same cycle: tx_rdy is still 0, so the load is ignored.
- done while doit=0: no effect.
- Config or out_port changes after edge N: no effect on the current frame.
- Reset mid-frame: everything returns to reset values on that edge. tx returns high immediately after the edge.

Optional Feature:
- TX_BREAK_EN defined: adds input brk (1 bit).
  - brk=1 while idle (doit=0, load_d1=0): tx forced 0, tx_rdy=0, loads ignored.
  - brk=1 mid-frame: has no effect until done, then applies.
  - brk deassert: tx=1 next clk, tx_rdy=1 the clk after.
- Undefined: no brk port; behaviour exactly as above.

Decomposition:
- Shared package uart_pkg:
  - FRAME_W=11, START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LVL.
  - Bit-index constants for bit9/bit10.
  - Parity-mode encoding {eight,pen,ohel}.
- Sub-module uart_frame_build: combinational; data[7:0] + eight/pen/ohel → 11-bit frame. Reused by the RX checker for expected-parity compare.

Test Plan:
- Reset → tx=1, doit=0, tx_rdy=1; 20 btu pulses with reset held → tx stays 1.
- 8N1 (eight=1, pen=0), out_port=8'hA5, load 1 clk → sr=11'b11010010101. On successive btu, tx = 1,0,1,0,1,0,0,1,0,1,1. doit drops on done; tx_rdy=1 one clk later.
- 7E1 (eight=0, pen=1, ohel=0), out_port=8'h41 → bit9=0, bit10=1. 8O1 with 8'hFF → bit9=1, bit10=1. 8E1 with 8'h01 → bit10=1.
- Load pulsed at mid-frame and again in the done cycle → both ignored; tx sequence unchanged; no second frame.
- btu coincident with the load_d1 cycle → frame loaded intact; first shift occurs on the next btu; start bit is not lost.
- Reset asserted after the 5th btu of a frame → next edge: tx=1, doit=0, tx_rdy=1. With TX_BREAK_EN: brk=1 idle → tx=0, load ignored; release → tx=1, tx_rdy=1 two clks later.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing constants, config encoding and parity helper.
package uart_pkg;

   localparam int   FRAME_W   = 11;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;
   localparam int   BIT9_IDX  = 9;
   localparam int   BIT10_IDX = 10;

   typedef struct packed {
      logic eight;
      logic pen;
      logic ohel;
   } cfg_t;

   typedef enum logic [2:0] {
      MODE_7N1 = 3'b000,
      MODE_7E1 = 3'b010,
      MODE_7O1 = 3'b011,
      MODE_8N1 = 3'b100,
      MODE_8E1 = 3'b110,
      MODE_8O1 = 3'b111
   } mode_t;

   // Parity covers only the bits actually sent as data.
   function automatic logic parity_bit(input logic [7:0] d, input cfg_t c);
      return (c.eight ? ^d : ^d[6:0]) ^ c.ohel;
   endfunction

endpackage

// File: rtl/uart_frame_build.sv
// uart_frame_build: combinational byte + framing config to 11-bit LSB-first frame.
module uart_frame_build
   import uart_pkg::*;
(
   input  logic [7:0]         data_i,
   input  cfg_t               cfg_i,
   output logic [FRAME_W-1:0] frame_o
);

   logic par;

   assign par = parity_bit(data_i, cfg_i);

   always_comb begin
      frame_o            = {FRAME_W{STOP_BIT}};
      frame_o[0]         = IDLE_LVL;
      frame_o[1]         = START_BIT;
      frame_o[8:2]       = data_i[6:0];
      frame_o[BIT9_IDX]  = cfg_i.eight ? data_i[7] : (cfg_i.pen ? par : STOP_BIT);
      frame_o[BIT10_IDX] = (cfg_i.eight & cfg_i.pen) ? par : STOP_BIT;
   end

endmodule

// File: rtl/uart_tx_shift.sv
// uart_tx_shift: UART TX frame loader and LSB-first shift engine.
// Optional TX_BREAK_EN adds brk input that holds the line low while idle.
module uart_tx_shift #(
   parameter int   FRAME_W  = uart_pkg::FRAME_W,
   parameter logic IDLE_LVL = uart_pkg::IDLE_LVL
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btu,
   input  logic       done,
   input  logic       load,
   input  logic [7:0] out_port,
   input  logic       eight,
   input  logic       pen,
   input  logic       ohel,
`ifdef TX_BREAK_EN
   input  logic       brk,
`endif
   output logic       doit,
   output logic       tx,
   output logic       tx_rdy
);

   import uart_pkg::cfg_t;

   logic [FRAME_W-1:0] sr_q, sr_d, frame;
   logic [7:0]         data_q, data_d;
   cfg_t               cfg_q, cfg_d;
   logic               load_d1_q, doit_q, doit_d, tx_rdy_q, tx_rdy_d;
   logic               accept, brk_set, brk_q;

   uart_frame_build u_fb (
      .data_i  (data_q),
      .cfg_i   (cfg_q),
      .frame_o (frame)
   );

`ifdef TX_BREAK_EN
   // Break only takes hold between frames; an active frame finishes first.
   assign brk_set = brk & ~doit_q & ~load_d1_q;
   always_ff @(posedge clk) begin
      if (reset) brk_q <= 1'b0;
      else       brk_q <= brk_set;
   end
`else
   assign brk_set = 1'b0;
   assign brk_q   = 1'b0;
`endif

   always_comb begin
      accept   = load & tx_rdy_q & ~brk_set;
      data_d   = accept ? out_port : data_q;
      cfg_d    = accept ? cfg_t'({eight, pen, ohel}) : cfg_q;
      sr_d     = load_d1_q ? frame : ((doit_q & btu) ? {IDLE_LVL, sr_q[FRAME_W-1:1]} : sr_q);
      doit_d   = load_d1_q | (doit_q & ~done);
      tx_rdy_d = ~accept & ~doit_q & ~load_d1_q & ~brk_q & ~brk_set;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q      <= {FRAME_W{IDLE_LVL}};
         data_q    <= '0;
         cfg_q     <= '0;
         load_d1_q <= 1'b0;
         doit_q    <= 1'b0;
         tx_rdy_q  <= 1'b1;
      end else begin
         sr_q      <= sr_d;
         data_q    <= data_d;
         cfg_q     <= cfg_d;
         load_d1_q <= accept;
         doit_q    <= doit_d;
         tx_rdy_q  <= tx_rdy_d;
      end
   end

   assign tx     = sr_q[0] & ~brk_q;
   assign doit   = doit_q;
   assign tx_rdy = tx_rdy_q;

endmodule

// File: tb/tb_uart_tx_shift.sv
// tb_uart_tx_shift: directed self-checking bench for uart_tx_shift.
module tb_uart_tx_shift;

   logic clk = 1'b0, reset = 1'b1, btu = 1'b0, done = 1'b0, load = 1'b0;
   logic [7:0] out_port = 8'h00;
   logic eight = 1'b0, pen = 1'b0, ohel = 1'b0;
   logic doit, tx, tx_rdy;
`ifdef TX_BREAK_EN
   logic brk = 1'b0;
`endif
   int vecs = 0, errs = 0;

   logic [7:0]  dv [8] = '{8'hA5, 8'h41, 8'hFF, 8'h01, 8'h41, 8'hC3, 8'h5A, 8'h03};
   logic [2:0]  cv [8] = '{3'b100, 3'b010, 3'b111, 3'b110, 3'b011, 3'b000, 3'b100, 3'b110};
   logic [10:0] fv [8] = '{11'b11010010101, 11'b10100000101, 11'b11111111101, 11'b10000000101,
                           11'b11100000101, 11'b11100001101, 11'b10101101001, 11'b00000001101};

   uart_tx_shift dut (
      .clk(clk), .reset(reset), .btu(btu), .done(done), .load(load), .out_port(out_port),
      .eight(eight), .pen(pen), .ohel(ohel),
`ifdef TX_BREAK_EN
      .brk(brk),
`endif
      .doit(doit), .tx(tx), .tx_rdy(tx_rdy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick;
      for (int i = 0; i < 20; i++) begin
         btu = 1'b1; tick; btu = 1'b0; tick;
         vecs++;
         if (tx !== 1'b1) begin errs++; $display("FAIL reset_btu[%0d]: tx=%b expected 1", i, tx); end
      end
      vecs++;
      if (doit !== 1'b0 || tx_rdy !== 1'b1)
         begin errs++; $display("FAIL reset_state: doit=%b tx_rdy=%b expected 0 1", doit, tx_rdy); end
      reset = 1'b0;
      tick;
   endtask

   task automatic test_frames;
      for (int k = 0; k < 8; k++) begin
         out_port = dv[k]; {eight, pen, ohel} = cv[k]; load = 1'b1; tick;
         load = 1'b0; out_port = ~dv[k]; {eight, pen, ohel} = ~cv[k]; tick;
         vecs++;
         if (tx !== fv[k][0] || doit !== 1'b1 || tx_rdy !== 1'b0)
            begin errs++; $display("FAIL frame%0d_load: tx=%b doit=%b rdy=%b expected %b 1 0", k, tx, doit, tx_rdy, fv[k][0]); end
         for (int i = 1; i < 11; i++) begin
            btu = 1'b1; tick; btu = 1'b0;
            vecs++;
            if (tx !== fv[k][i]) begin errs++; $display("FAIL frame%0d_bit%0d: tx=%b expected %b", k, i, tx, fv[k][i]); end
            tick;
         end
         btu = 1'b1; tick; btu = 1'b0; tick;
         vecs++;
         if (tx !== 1'b1 || doit !== 1'b1)
            begin errs++; $display("FAIL frame%0d_tail: tx=%b doit=%b expected 1 1", k, tx, doit); end
         done = 1'b1; tick; done = 1'b0;
         vecs++;
         if (doit !== 1'b0 || tx_rdy !== 1'b0)
            begin errs++; $display("FAIL frame%0d_done: doit=%b rdy=%b expected 0 0", k, doit, tx_rdy); end
         tick;
         vecs++;
         if (tx_rdy !== 1'b1) begin errs++; $display("FAIL frame%0d_rdy: tx_rdy=%b expected 1", k, tx_rdy); end
      end
   endtask

   task automatic test_ignored_loads;
      out_port = 8'hA5; {eight, pen, ohel} = 3'b100; load = 1'b1; tick; load = 1'b0; tick;
      for (int i = 1; i < 12; i++) begin
         btu = 1'b1; tick; btu = 1'b0;
         vecs++;
         if (tx !== (i < 11 ? fv[0][i] : 1'b1))
            begin errs++; $display("FAIL ignore_bit%0d: tx=%b expected %b", i, tx, (i < 11 ? fv[0][i] : 1'b1)); end
         if (i == 5) begin out_port = 8'h00; {eight, pen, ohel} = 3'b011; load = 1'b1; end
         tick;
         load = 1'b0;
      end
      done = 1'b1; load = 1'b1; tick; done = 1'b0; load = 1'b0;
      vecs++;
      if (doit !== 1'b0 || tx_rdy !== 1'b0)
         begin errs++; $display("FAIL ignore_done: doit=%b rdy=%b expected 0 0", doit, tx_rdy); end
      tick; tick; tick;
      vecs++;
      if (doit !== 1'b0 || tx_rdy !== 1'b1 || tx !== 1'b1)
         begin errs++; $display("FAIL ignore_no_frame: doit=%b rdy=%b tx=%b expected 0 1 1", doit, tx_rdy, tx); end
   endtask

   task automatic test_btu_on_load;
      out_port = 8'hA5; {eight, pen, ohel} = 3'b100; load = 1'b1; tick;
      load = 1'b0; btu = 1'b1; tick; btu = 1'b0;
      vecs++;
      if (tx !== 1'b1 || doit !== 1'b1)
         begin errs++; $display("FAIL btu_load: tx=%b doit=%b expected 1 1", tx, doit); end
      tick;
      for (int i = 1; i < 11; i++) begin
         btu = 1'b1; tick; btu = 1'b0;
         vecs++;
         if (tx !== fv[0][i]) begin errs++; $display("FAIL btu_load_bit%0d: tx=%b expected %b", i, tx, fv[0][i]); end
         tick;
      end
      done = 1'b1; tick; done = 1'b0; tick;
      vecs++;
      if (tx_rdy !== 1'b1 || doit !== 1'b0)
         begin errs++; $display("FAIL btu_load_end: rdy=%b doit=%b expected 1 0", tx_rdy, doit); end
   endtask

   task automatic test_reset_midframe;
      out_port = 8'h5A; {eight, pen, ohel} = 3'b100; load = 1'b1; tick; load = 1'b0; tick;
      for (int i = 1; i < 6; i++) begin btu = 1'b1; tick; btu = 1'b0; tick; end
      vecs++;
      if (tx !== fv[6][5]) begin errs++; $display("FAIL mid_bit5: tx=%b expected %b", tx, fv[6][5]); end
      reset = 1'b1; tick; reset = 1'b0;
      vecs++;
      if (tx !== 1'b1 || doit !== 1'b0 || tx_rdy !== 1'b1)
         begin errs++; $display("FAIL mid_reset: tx=%b doit=%b rdy=%b expected 1 0 1", tx, doit, tx_rdy); end
      btu = 1'b1; tick; btu = 1'b0; tick;
      vecs++;
      if (tx !== 1'b1 || doit !== 1'b0)
         begin errs++; $display("FAIL mid_after: tx=%b doit=%b expected 1 0", tx, doit); end
   endtask

`ifdef TX_BREAK_EN
   task automatic test_break;
      brk = 1'b1; tick;
      vecs++;
      if (tx !== 1'b0 || tx_rdy !== 1'b0)
         begin errs++; $display("FAIL brk_on: tx=%b rdy=%b expected 0 0", tx, tx_rdy); end
      out_port = 8'hA5; {eight, pen, ohel} = 3'b100; load = 1'b1; tick; load = 1'b0; tick;
      vecs++;
      if (doit !== 1'b0 || tx !== 1'b0)
         begin errs++; $display("FAIL brk_load: doit=%b tx=%b expected 0 0", doit, tx); end
      brk = 1'b0; tick;
      vecs++;
      if (tx !== 1'b1 || tx_rdy !== 1'b0)
         begin errs++; $display("FAIL brk_off1: tx=%b rdy=%b expected 1 0", tx, tx_rdy); end
      tick;
      vecs++;
      if (tx_rdy !== 1'b1 || doit !== 1'b0)
         begin errs++; $display("FAIL brk_off2: rdy=%b doit=%b expected 1 0", tx_rdy, doit); end
   endtask
`endif

   initial begin
      test_reset;
      test_frames;
      test_ignored_loads;
      test_btu_on_load;
      test_reset_midframe;
`ifdef TX_BREAK_EN
      test_break;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
